// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared bus types and constants for the writeback register file.
//   Types   : reg_bus_t (32-bit data word), reg_addr_bus_t (5-bit GPR address)
//   Consts  : ZeroWord, NOPRegAddr, WriteEnable, ReadEnable, RstAssert
//   Helper  : gpr_read_mux() - priority-ordered read selection for one GPR port
package wb_regfile_pkg;

   typedef logic [31:0] reg_bus_t;
   typedef logic [4:0]  reg_addr_bus_t;

   localparam int unsigned RegNum      = 32;
   localparam reg_bus_t      ZeroWord    = 32'h0000_0000;
   localparam reg_addr_bus_t NOPRegAddr  = 5'b00000;
   localparam logic          WriteEnable = 1'b1;
   localparam logic          ReadEnable  = 1'b1;
   localparam logic          RstAssert   = 1'b1;

   // Reset, disabled port and r0 all force zero before any forwarding or array lookup.
   function automatic reg_bus_t gpr_read_mux(input logic          rst,
                                             input logic          re,
                                             input reg_addr_bus_t raddr,
                                             input logic          fwd_hit,
                                             input reg_bus_t      fwd_data,
                                             input reg_bus_t      stored);
      if (rst == RstAssert)        return ZeroWord;
      else if (re != ReadEnable)   return ZeroWord;
      else if (raddr == NOPRegAddr) return ZeroWord;
      else if (fwd_hit)            return fwd_data;
      else                         return stored;
   endfunction

endpackage

// File: rtl/wb_hilo_reg.sv
// wb_hilo_reg: HI/LO register pair with optional same-cycle write bypass.
//   clk, rst        : clock, asynchronous active-high reset
//   wb_whilo        : HI/LO write enable (both halves written together)
//   wb_hi, wb_lo    : write data
//   hi_o, lo_o      : current HI/LO (forced to zero while rst is high)
// BYPASS=1 shows wb_hi/wb_lo on the outputs during the write cycle.
module wb_hilo_reg
   import wb_regfile_pkg::*;
#(
   parameter bit BYPASS = 1'b0
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     wb_whilo,
   input  reg_bus_t wb_hi,
   input  reg_bus_t wb_lo,
   output reg_bus_t hi_o,
   output reg_bus_t lo_o
);

   reg_bus_t hi_q;
   reg_bus_t lo_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q <= ZeroWord;
         lo_q <= ZeroWord;
      end else if (wb_whilo == WriteEnable) begin
         hi_q <= wb_hi;
         lo_q <= wb_lo;
      end
   end

   always_comb begin
      hi_o = hi_q;
      lo_o = lo_q;
      if (rst == RstAssert) begin
         hi_o = ZeroWord;
         lo_o = ZeroWord;
      end else if (BYPASS && (wb_whilo == WriteEnable)) begin
         hi_o = wb_hi;
         lo_o = wb_lo;
      end
   end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback-stage GPR file (r0 hardwired zero), HI/LO pair and
// retired-write counter.
//   clk, rst                    : clock, asynchronous active-high reset
//   wb_wreg, wb_wd, wb_wdata    : GPR write bundle from MEM/WB
//   wb_whilo, wb_hi, wb_lo      : HI/LO write bundle from MEM/WB
//   re1/raddr1/rdata1           : combinational read port 1 (to ID)
//   re2/raddr2/rdata2           : combinational read port 2 (to ID)
//   hi_o, lo_o                  : HI/LO read-out (to EX)
//   wr_count                    : number of accepted GPR writes, wraps silently
// Build option: define WB_REGFILE_BYPASS_EN to forward the in-flight write to
// the read ports and HI/LO outputs in the same cycle.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int unsigned NUM_REGS = RegNum,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wb_wreg,
   input  reg_addr_bus_t    wb_wd,
   input  reg_bus_t         wb_wdata,
   input  logic             wb_whilo,
   input  reg_bus_t         wb_hi,
   input  reg_bus_t         wb_lo,
   input  logic             re1,
   input  reg_addr_bus_t    raddr1,
   output reg_bus_t         rdata1,
   input  logic             re2,
   input  reg_addr_bus_t    raddr2,
   output reg_bus_t         rdata2,
   output reg_bus_t         hi_o,
   output reg_bus_t         lo_o,
   output logic [CNT_W-1:0] wr_count
);

`ifdef WB_REGFILE_BYPASS_EN
   localparam bit BypassEn = 1'b1;
`else
   localparam bit BypassEn = 1'b0;
`endif

   reg_bus_t         regs [NUM_REGS];
   logic [CNT_W-1:0] wr_count_q;
   logic             wr_accept;
   logic             hit1;
   logic             hit2;

   // Writes to r0 are neither stored nor counted.
   assign wr_accept = (wb_wreg == WriteEnable) && (wb_wd != NOPRegAddr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= ZeroWord;
         wr_count_q <= '0;
      end else if (wr_accept) begin
         regs[wb_wd] <= wb_wdata;
         wr_count_q  <= wr_count_q + CNT_W'(1);
      end
   end

   assign hit1 = BypassEn && (wb_wreg == WriteEnable) && (wb_wd == raddr1);
   assign hit2 = BypassEn && (wb_wreg == WriteEnable) && (wb_wd == raddr2);

   always_comb begin
      rdata1 = gpr_read_mux(rst, re1, raddr1, hit1, wb_wdata, regs[raddr1]);
      rdata2 = gpr_read_mux(rst, re2, raddr2, hit2, wb_wdata, regs[raddr2]);
   end

   assign wr_count = wr_count_q;

   wb_hilo_reg #(
      .BYPASS (BypassEn)
   ) u_hilo (
      .clk      (clk),
      .rst      (rst),
      .wb_whilo (wb_whilo),
      .wb_hi    (wb_hi),
      .wb_lo    (wb_lo),
      .hi_o     (hi_o),
      .lo_o     (lo_o)
   );

endmodule
